// File: rtl/eq_gain_ctrl_if.sv
// Single-band gain request channel between the key/UART control path and eq_gain_ctrl.
// A request transfers on a cycle where cfg_valid and cfg_ready are both high.
interface eq_gain_ctrl_if #(
  parameter int GAIN_W = 5
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [3:0]        cfg_band;
  logic [GAIN_W-1:0] cfg_gain;

  modport master (output cfg_valid, output cfg_band, output cfg_gain, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_band, input cfg_gain, output cfg_ready);
endinterface

// File: rtl/eq_gain_ctrl.sv
// Gain-write sequencer for the equalizer: reset hold, preset ROM loads, single-band writes
// and a shadow copy of every band gain for readback.
module eq_gain_ctrl #(
  parameter int NUM_BANDS  = 8,
  parameter int GAIN_W     = 5,
  parameter int RST_CYCLES = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  eq_gain_ctrl_if.slave     cfg,
  input  logic              preset_load,
  input  logic [1:0]        preset_sel,
  input  logic              eq_reinit,
  output logic              eq_rst,
  output logic              gainwe,
  output logic [3:0]        gain_addr,
  output logic [GAIN_W-1:0] gainset,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  input  logic [3:0]        rd_band,
  output logic [GAIN_W-1:0] rd_gain
);

  localparam int GAIN_MID = 2 ** (GAIN_W - 1);
  localparam int GAIN_MAX = 2 ** GAIN_W - 1;
  localparam int CNT_W    = $clog2(RST_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [3:0]       BAND_LAST   = 4'(NUM_BANDS - 1);
  localparam logic [3:0]       BAND_PREV   = 4'(NUM_BANDS - 2);
  localparam logic [4:0]       NUM_BANDS_W = 5'(NUM_BANDS);

  typedef enum logic [1:0] {
    RST_EQ,
    IDLE,
    SETUP,
    STROBE
  } state_e;

  function automatic logic [GAIN_W-1:0] preset_gain(input logic [1:0] sel, input logic [3:0] band);
    int g;
    g = GAIN_MID;
    case (sel)
      2'd1:    if (band == 4'd0 || band == 4'd1) g = GAIN_MID + 8;
      2'd2:    if (band == 4'd3 || band == 4'd4) g = GAIN_MID + 6;
      2'd3:    if (band == BAND_PREV || band == BAND_LAST) g = GAIN_MID + 8;
      default: g = GAIN_MID;
    endcase
    if (g > GAIN_MAX) g = GAIN_MAX;
    return GAIN_W'(g);
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        band_q, band_d;
  logic [1:0]        sel_q, sel_d;
  logic              load_q, load_d;
  logic              eq_rst_q, eq_rst_d;
  logic              gainwe_q, gainwe_d;
  logic [3:0]        gain_addr_q, gain_addr_d;
  logic [GAIN_W-1:0] gainset_q, gainset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic [GAIN_W-1:0] shadow_q [NUM_BANDS];
  logic [GAIN_W-1:0] shadow_d [NUM_BANDS];

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    band_d      = band_q;
    sel_d       = sel_q;
    load_d      = load_q;
    gain_addr_d = gain_addr_q;
    gainset_d   = gainset_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    shadow_d    = shadow_q;

    case (state_q)
      RST_EQ: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = SETUP;
          cnt_d       = '0;
          band_d      = 4'd0;
          sel_d       = 2'd0;
          load_d      = 1'b1;
          gain_addr_d = 4'd0;
          gainset_d   = preset_gain(2'd0, 4'd0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (eq_reinit) begin
          state_d = RST_EQ;
          cnt_d   = '0;
        end else if (preset_load) begin
          state_d     = SETUP;
          sel_d       = preset_sel;
          band_d      = 4'd0;
          load_d      = 1'b1;
          gain_addr_d = 4'd0;
          gainset_d   = preset_gain(preset_sel, 4'd0);
        end else if (cfg.cfg_valid && cfg_ready_q) begin
          if ({1'b0, cfg.cfg_band} < NUM_BANDS_W) begin
            state_d     = SETUP;
            band_d      = cfg.cfg_band;
            load_d      = 1'b0;
            gain_addr_d = cfg.cfg_band;
            gainset_d   = (int'(cfg.cfg_gain) > GAIN_MAX) ? GAIN_W'(GAIN_MAX) : cfg.cfg_gain;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (eq_reinit) begin
          state_d = RST_EQ;
          cnt_d   = '0;
        end else begin
          state_d = STROBE;
        end
      end
      STROBE: begin
        // An abort here must not commit the band that was being strobed.
        if (eq_reinit) begin
          state_d = RST_EQ;
          cnt_d   = '0;
        end else begin
          for (int i = 0; i < NUM_BANDS; i++) begin
            if (gain_addr_q == i[3:0]) shadow_d[i] = gainset_q;
          end
          if (!load_q || band_q == BAND_LAST) begin
            state_d = IDLE;
            done_d  = load_q;
          end else begin
            state_d     = SETUP;
            band_d      = band_q + 4'd1;
            gain_addr_d = band_q + 4'd1;
            gainset_d   = preset_gain(sel_q, band_q + 4'd1);
          end
        end
      end
      default: state_d = RST_EQ;
    endcase

    // Outputs are registered versions of what the next state implies.
    eq_rst_d    = (state_d == RST_EQ);
    gainwe_d    = (state_d == STROBE);
    busy_d      = (state_d != IDLE);
    cfg_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= RST_EQ;
      cnt_q       <= '0;
      band_q      <= 4'd0;
      sel_q       <= 2'd0;
      load_q      <= 1'b0;
      eq_rst_q    <= 1'b1;
      gainwe_q    <= 1'b0;
      gain_addr_q <= 4'd0;
      gainset_q   <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
      // NOTE: the shadow array is small and its readback must show 0 after reset, so it is reset here.
      for (int i = 0; i < NUM_BANDS; i++) shadow_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from the same edge.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      band_q      <= band_d;
      sel_q       <= sel_d;
      load_q      <= load_d;
      eq_rst_q    <= eq_rst_d;
      gainwe_q    <= gainwe_d;
      gain_addr_q <= gain_addr_d;
      gainset_q   <= gainset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      cfg_ready_q <= cfg_ready_d;
      for (int i = 0; i < NUM_BANDS; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  always_comb begin
    rd_gain = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (rd_band == i[3:0]) rd_gain = shadow_q[i];
    end
  end

  assign eq_rst        = eq_rst_q;
  assign gainwe        = gainwe_q;
  assign gain_addr     = gain_addr_q;
  assign gainset       = gainset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign cfg.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Self-checking bench for eq_gain_ctrl: directed scenarios plus random traffic against a
// transaction-level model of the band gains and the documented cycle timing.
module tb_eq_gain_ctrl;

  localparam int NB  = 8;
  localparam int GW  = 5;
  localparam int RC  = 16;
  localparam int MID = 2 ** (GW - 1);
  localparam int MAX = 2 ** GW - 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          preset_load;
  logic [1:0]    preset_sel;
  logic          eq_reinit;
  logic          eq_rst;
  logic          gainwe;
  logic [3:0]    gain_addr;
  logic [GW-1:0] gainset;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [3:0]    rd_band;
  logic [GW-1:0] rd_gain;

  int n_cmp = 0;
  int n_err = 0;
  int model [16];
  bit prev_we = 1'b0;

  eq_gain_ctrl_if #(.GAIN_W(GW)) cfg_if ();

  eq_gain_ctrl #(.NUM_BANDS(NB), .GAIN_W(GW), .RST_CYCLES(RC)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cfg         (cfg_if),
    .preset_load (preset_load),
    .preset_sel  (preset_sel),
    .eq_reinit   (eq_reinit),
    .eq_rst      (eq_rst),
    .gainwe      (gainwe),
    .gain_addr   (gain_addr),
    .gainset     (gainset),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .rd_band     (rd_band),
    .rd_gain     (rd_gain)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Preset contents straight from the preset table.
  function automatic int exp_preset(input int sel, input int b);
    int g;
    g = MID;
    if (sel == 1 && b < 2) g = MID + 8;
    if (sel == 2 && (b == 3 || b == 4)) g = MID + 6;
    if (sel == 3 && b >= NB - 2) g = MID + 8;
    return (g > MAX) ? MAX : g;
  endfunction

  // Structural invariants of the strobe stream.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      check("we_with_eq_rst", gainwe & eq_rst, 0);
      check("we_back_to_back", gainwe & prev_we, 0);
      prev_we = gainwe;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int b = 0; b < 16; b++) begin
      rd_band = b[3:0];
      #1;
      check({tag, "/rd_gain"}, rd_gain, (b < NB) ? model[b] : 0);
    end
  endtask

  // Follows a whole preset load from cycle 0 (request cycle, or first eq_rst cycle when
  // n_rst > 0) through the done pulse, checking every cycle against the timing rules.
  task automatic track_load(input string tag, input int sel, input int n_rst,
                            input bit hold_cfg, input int reinit_at);
    int we0, last, b;
    bit exp_we, exp_ready;
    we0  = (n_rst == 0) ? 2 : n_rst + 1;
    last = we0 + 2 * NB - 1;
    if (n_rst == 0) begin
      preset_load = 1'b1;
      preset_sel  = sel[1:0];
    end
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        step();
        preset_load = 1'b0;
        if (!hold_cfg) cfg_if.cfg_valid = 1'b0;
      end
      eq_reinit = (k == reinit_at);
      exp_we    = (k >= we0) && (k <= we0 + 2 * (NB - 1)) && ((k - we0) % 2 == 0);
      exp_ready = (k == last) || (k == 0 && n_rst == 0);
      b         = (k - we0) / 2;
      check({tag, "/eq_rst"}, eq_rst, k < n_rst);
      check({tag, "/gainwe"}, gainwe, exp_we);
      check({tag, "/done"}, done, k == last);
      check({tag, "/cfg_ready"}, cfg_if.cfg_ready, exp_ready);
      check({tag, "/busy"}, busy, !exp_ready);
      check({tag, "/cfg_err"}, cfg_err, 0);
      if (exp_we) begin
        check({tag, "/gain_addr"}, gain_addr, b);
        check({tag, "/gainset"}, gainset, exp_preset(sel, b));
        model[b] = exp_preset(sel, b);
      end
    end
  endtask

  // The request is on the bus and accepted in the current cycle.
  task automatic write_tail(input string tag, input int band, input int gain);
    step();
    cfg_if.cfg_valid = 1'b0;
    check({tag, "/setup_we"}, gainwe, 0);
    check({tag, "/setup_addr"}, gain_addr, band);
    check({tag, "/setup_gain"}, gainset, gain);
    check({tag, "/setup_ready"}, cfg_if.cfg_ready, 0);
    check({tag, "/setup_busy"}, busy, 1);
    check({tag, "/setup_err"}, cfg_err, 0);
    step();
    check({tag, "/strobe_we"}, gainwe, 1);
    check({tag, "/strobe_addr"}, gain_addr, band);
    check({tag, "/strobe_gain"}, gainset, gain);
    model[band] = gain;
    step();
    check({tag, "/after_we"}, gainwe, 0);
    check({tag, "/after_ready"}, cfg_if.cfg_ready, 1);
    check({tag, "/after_done"}, done, 0);
    rd_band = band[3:0];
    #1;
    check({tag, "/rd_gain"}, rd_gain, gain);
  endtask

  task automatic do_write(input string tag, input int band, input int gain);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_band  = band[3:0];
    cfg_if.cfg_gain  = gain[GW-1:0];
    write_tail(tag, band, gain);
  endtask

  task automatic do_bad(input string tag, input int band);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_band  = band[3:0];
    cfg_if.cfg_gain  = GW'($urandom);
    step();
    cfg_if.cfg_valid = 1'b0;
    check({tag, "/err"}, cfg_err, 1);
    check({tag, "/we"}, gainwe, 0);
    check({tag, "/ready"}, cfg_if.cfg_ready, 1);
    check({tag, "/busy"}, busy, 0);
    step();
    check({tag, "/err_end"}, cfg_err, 0);
    check({tag, "/we_end"}, gainwe, 0);
  endtask

  initial begin
    sys_rst          = 1'b1;
    preset_load      = 1'b0;
    preset_sel       = 2'd0;
    eq_reinit        = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_band  = 4'd0;
    cfg_if.cfg_gain  = '0;
    rd_band          = 4'd0;
    for (int i = 0; i < 16; i++) model[i] = 0;

    step();
    step();
    check("rst/eq_rst", eq_rst, 1);
    check("rst/busy", busy, 1);
    check("rst/gainwe", gainwe, 0);
    check("rst/gain_addr", gain_addr, 0);
    check("rst/gainset", gainset, 0);
    check("rst/cfg_ready", cfg_if.cfg_ready, 0);
    check("rst/done", done, 0);
    check("rst/cfg_err", cfg_err, 0);
    check("rst/rd_gain", rd_gain, 0);

    // Power-up: release lands inside cycle 0.
    step();
    sys_rst = 1'b0;
    track_load("pwr", 0, RC, 1'b0, -1);
    sweep("pwr");

    do_write("single", 5, 31);
    sweep("single");

    do_bad("bad9", 9);
    sweep("bad9");

    // Preset beats a same-cycle band write; the write is dropped.
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_band  = 4'd5;
    cfg_if.cfg_gain  = 5'd7;
    track_load("prio", 1, 0, 1'b0, -1);
    sweep("prio");

    // Abort preset 3 on its third strobe after giving band 2 a distinctive value.
    do_write("pre_abort", 2, MID - 3);
    preset_load = 1'b1;
    preset_sel  = 2'd3;
    for (int k = 1; k <= 6; k++) begin
      step();
      preset_load = 1'b0;
      check("abort/gainwe", gainwe, (k % 2) == 0);
      if (k % 2 == 0) begin
        check("abort/gain_addr", gain_addr, k / 2 - 1);
        if (k < 6) model[k / 2 - 1] = exp_preset(3, k / 2 - 1);
      end
    end
    eq_reinit = 1'b1;
    step();
    eq_reinit = 1'b0;
    check("abort/we_drop", gainwe, 0);
    check("abort/eq_rst", eq_rst, 1);
    check("abort/busy", busy, 1);
    rd_band = 4'd2;
    #1;
    check("abort/no_commit", rd_gain, model[2]);
    track_load("reinit", 0, RC, 1'b0, 5);
    sweep("reinit");

    // Back-pressure: band write held through a preset, taken on the first idle cycle.
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_band  = 4'd6;
    cfg_if.cfg_gain  = 5'd3;
    track_load("bp", 2, 0, 1'b1, -1);
    write_tail("bp_write", 6, 3);
    sweep("bp");

    for (int it = 0; it < 30; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        do_write("rnd_write", $urandom_range(0, NB - 1), $urandom_range(0, MAX));
      end else if (op <= 6) begin
        do_bad("rnd_bad", $urandom_range(NB, 15));
      end else if (op <= 8) begin
        track_load("rnd_preset", $urandom_range(0, 3), 0, 1'b0, -1);
      end else begin
        eq_reinit = 1'b1;
        step();
        track_load("rnd_reinit", 0, RC, 1'b0, -1);
      end
      sweep("rnd");
    end

    // Asynchronous reset in the middle of a preset load.
    preset_load = 1'b1;
    preset_sel  = 2'd1;
    step();
    preset_load = 1'b0;
    step();
    step();
    #3;
    sys_rst = 1'b1;
    #1;
    check("midrst/eq_rst", eq_rst, 1);
    check("midrst/busy", busy, 1);
    check("midrst/gainwe", gainwe, 0);
    check("midrst/gain_addr", gain_addr, 0);
    check("midrst/gainset", gainset, 0);
    check("midrst/cfg_ready", cfg_if.cfg_ready, 0);
    check("midrst/done", done, 0);
    rd_band = 4'd0;
    #1;
    check("midrst/rd_gain", rd_gain, 0);
    for (int i = 0; i < 16; i++) model[i] = 0;
    step();
    step();
    sys_rst = 1'b0;
    track_load("pwr2", 0, RC, 1'b0, -1);
    sweep("pwr2");

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
